// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter for a single-port word RAM; partial stores run as read-modify-write.
// Define MEM_ARB_FIXED_PRIORITY_EN to replace round-robin with fixed port-0 priority.
module mem_arbiter #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_W-1:0]     addr0,
    input  logic [DATA_W-1:0]     wdata0,
    input  logic [DATA_W/8-1:0]   be0,
    output logic                  ack0,
    output logic [DATA_W-1:0]     rdata0,
    output logic                  err0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_W-1:0]     addr1,
    input  logic [DATA_W-1:0]     wdata1,
    input  logic [DATA_W/8-1:0]   be1,
    output logic                  ack1,
    output logic [DATA_W-1:0]     rdata1,
    output logic                  err1,
    output logic                  ram_we,
    output logic                  ram_re,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [DATA_W-1:0]     ram_wdata,
    input  logic [DATA_W-1:0]     ram_rdata
);
    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, ACCESS, MERGE, DONE} state_t;

    state_t              state_q, state_d;
    logic                port_q, port_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic                err_q, err_d;
    // Holds the read word for reads, or the merged word for partial writes.
    logic [DATA_W-1:0]   word_q, word_d;

    logic                sel;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic [BE_W-1:0]     sel_be;
    logic [DATA_W-1:0]   merged;

`ifdef MEM_ARB_FIXED_PRIORITY_EN
    assign sel = ~req0;
`else
    logic last_q, last_d;
    assign sel = (req0 && req1) ? ~last_q : req1;
`endif

    assign sel_we    = sel ? we1    : we0;
    assign sel_addr  = sel ? addr1  : addr0;
    assign sel_wdata = sel ? wdata1 : wdata0;
    assign sel_be    = sel ? be1    : be0;

    always_comb begin
        merged = ram_rdata;
        for (int i = 0; i < BE_W; i++) begin
            if (be_q[i]) merged[i*8 +: 8] = wdata_q[i*8 +: 8];
        end
    end

    always_comb begin
        state_d   = state_q;
        port_d    = port_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        err_d     = err_q;
        word_d    = word_q;
`ifndef MEM_ARB_FIXED_PRIORITY_EN
        last_d    = last_q;
`endif
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        ack0      = 1'b0;
        ack1      = 1'b0;
        rdata0    = '0;
        rdata1    = '0;
        err0      = 1'b0;
        err1      = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    port_d  = sel;
                    we_d    = sel_we;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    be_d    = sel_be;
                    word_d  = '0;
                    err_d   = (sel_addr[1:0] != 2'b00) || (sel_we && (sel_be == '0));
`ifndef MEM_ARB_FIXED_PRIORITY_EN
                    last_d  = sel;
`endif
                    state_d = err_d ? DONE : ACCESS;
                end
            end
            ACCESS: begin
                ram_addr = addr_q;
                if (!we_q) begin
                    ram_re  = 1'b1;
                    word_d  = ram_rdata;
                    state_d = DONE;
                end else if (be_q == '1) begin
                    ram_we    = 1'b1;
                    ram_wdata = wdata_q;
                    state_d   = DONE;
                end else begin
                    ram_re  = 1'b1;
                    word_d  = merged;
                    state_d = MERGE;
                end
            end
            MERGE: begin
                ram_we    = 1'b1;
                ram_addr  = addr_q;
                ram_wdata = word_q;
                state_d   = DONE;
            end
            DONE: begin
                if (port_q) begin
                    ack1   = 1'b1;
                    rdata1 = we_q ? '0 : word_q;
                    err1   = err_q;
                end else begin
                    ack0   = 1'b1;
                    rdata0 = we_q ? '0 : word_q;
                    err0   = err_q;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            port_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            err_q   <= 1'b0;
            word_q  <= '0;
`ifndef MEM_ARB_FIXED_PRIORITY_EN
            // Pretend port 1 went last so port 0 wins the first tie.
            last_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            port_q  <= port_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            err_q   <= err_d;
            word_q  <= word_d;
`ifndef MEM_ARB_FIXED_PRIORITY_EN
            last_q  <= last_d;
`endif
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model with per-cycle compare plus directed vectors.
module tb_mem_arbiter;
    localparam int AW = 14;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, we0, req1, we1;
    logic [AW-1:0] addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic [3:0]  be0, be1;
    logic        ack0, err0, ack1, err1;
    logic [31:0] rdata0, rdata1;
    logic        ram_we, ram_re;
    logic [AW-1:0] ram_addr;
    logic [31:0] ram_wdata, ram_rdata;

    logic [31:0] ram     [0:4095];
    logic [31:0] ref_mem [0:4095];
    logic        pl_we;
    logic [11:0] pl_idx;
    logic [31:0] pl_dat;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .be0(be0),
        .ack0(ack0), .rdata0(rdata0), .err0(err0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .be1(be1),
        .ack1(ack1), .rdata1(rdata1), .err1(err1),
        .ram_we(ram_we), .ram_re(ram_re), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    assign ram_rdata = ram[ram_addr[AW-1:2]];
    always @(posedge clk) begin
        if (ram_we) ram[ram_addr[AW-1:2]] <= ram_wdata;
        else if (pl_we) ram[pl_idx] <= pl_dat;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Reference model: one outstanding transaction, ack due at grant cycle + latency.
    int          cyc = 0;
    bit          busy = 0;
    int          last_gnt = 1;
    int          grant_log[$];
    int          m_port, m_ack_cyc, m_re_exp, m_we_exp;
    logic        m_we, m_err;
    logic [AW-1:0] m_addr;
    logic [11:0] m_idx;
    logic [31:0] m_wdata, m_rdata, m_new, m_old;
    logic [3:0]  m_be;
    int          re_cnt = 0, we_cnt = 0, tot_we = 0;
    int          last_re_cyc = 0, last_we_cyc = 0;
    logic [31:0] last_we_data = '0;

    always @(negedge clk) begin
        if (pl_we) ref_mem[pl_idx] = pl_dat;
        if (!reset) begin
            busy = 0;
            last_gnt = 1;
            grant_log.delete();
        end else begin
            cyc++;
            chk("ram_we_re_exclusive", {31'd0, ram_we & ram_re}, 0);
            if (ram_re) begin re_cnt++; last_re_cyc = cyc; end
            if (ram_we) begin we_cnt++; tot_we++; last_we_cyc = cyc; last_we_data = ram_wdata; end
            if (busy) begin
                if (ram_re || ram_we) chk("ram_addr", {18'd0, ram_addr}, {18'd0, m_addr});
                if (ram_we) chk("ram_wdata", ram_wdata, m_new);
                if (cyc == m_ack_cyc) begin
                    chk("ack0", {31'd0, ack0}, (m_port == 0) ? 1 : 0);
                    chk("ack1", {31'd0, ack1}, (m_port == 1) ? 1 : 0);
                    chk("rdata", m_port ? rdata1 : rdata0, m_rdata);
                    chk("err", {31'd0, m_port ? err1 : err0}, {31'd0, m_err});
                    chk("ram_re_count", re_cnt, m_re_exp);
                    chk("ram_we_count", we_cnt, m_we_exp);
                    if (m_we_exp != 0) ref_mem[m_idx] = m_new;
                    chk("ram_word", ram[m_idx], ref_mem[m_idx]);
                    busy = 0;
                end else begin
                    chk("ack_early", {31'd0, ack0 | ack1}, 0);
                end
            end else begin
                chk("idle_quiet", {28'd0, ack0, ack1, ram_we, ram_re}, 0);
                if (req0 || req1) begin
`ifdef MEM_ARB_FIXED_PRIORITY_EN
                    m_port = req0 ? 0 : 1;
`else
                    m_port = (req0 && req1) ? (1 - last_gnt) : (req0 ? 0 : 1);
`endif
                    last_gnt = m_port;
                    grant_log.push_back(m_port);
                    m_we    = m_port ? we1 : we0;
                    m_addr  = m_port ? addr1 : addr0;
                    m_wdata = m_port ? wdata1 : wdata0;
                    m_be    = m_port ? be1 : be0;
                    m_idx   = m_addr[AW-1:2];
                    m_old   = ref_mem[m_idx];
                    m_err   = (m_addr[1:0] != 2'b00) || (m_we && m_be == 4'h0);
                    for (int b = 0; b < 4; b++)
                        m_new[8*b +: 8] = m_be[b] ? m_wdata[8*b +: 8] : m_old[8*b +: 8];
                    m_rdata   = (!m_we && !m_err) ? m_old : 32'h0;
                    m_we_exp  = (m_we && !m_err) ? 1 : 0;
                    m_re_exp  = (!m_err && (!m_we || m_be != 4'hF)) ? 1 : 0;
                    m_ack_cyc = cyc + (m_err ? 1 : ((m_we && m_be != 4'hF) ? 3 : 2));
                    re_cnt = 0;
                    we_cnt = 0;
                    busy = 1;
                end
            end
        end
    end

    task automatic set_port(input int p, input logic rq, input logic we, input logic [AW-1:0] a,
                            input logic [31:0] d, input logic [3:0] be);
        if (p == 0) begin req0 = rq; we0 = we; addr0 = a; wdata0 = d; be0 = be; end
        else        begin req1 = rq; we1 = we; addr1 = a; wdata1 = d; be1 = be; end
    endtask

    task automatic wait_ack(input int p, output int lat, output logic [31:0] rd, output logic er);
        lat = -1; rd = '0; er = 1'b0;
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            if (p ? ack1 : ack0) begin
                lat = n; rd = p ? rdata1 : rdata0; er = p ? err1 : err0;
                break;
            end
        end
        if (lat < 0) begin
            checks++; failures++;
            $display("FAIL ack_timeout port=%0d actual=no_ack required=ack", p);
        end
    endtask

    task automatic do_req(input int p, input logic we, input logic [AW-1:0] a, input logic [31:0] d,
                          input logic [3:0] be, output int lat, output logic [31:0] rd, output logic er);
        @(posedge clk); #1;
        set_port(p, 1'b1, we, a, d, be);
        wait_ack(p, lat, rd, er);
        @(posedge clk); #1;
        set_port(p, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic port_stream(input int p, input int k);
        int lat; logic [31:0] rd; logic er;
        for (int i = 0; i < k; i++) begin
            @(posedge clk); #1;
            set_port(p, 1'b1, 1'b0, AW'(32'h40 + p * 32'h40 + i * 4), '0, '0);
            wait_ack(p, lat, rd, er);
        end
        @(posedge clk); #1;
        set_port(p, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        pl_we = 1'b1; pl_idx = a[AW-1:2]; pl_dat = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat; logic [31:0] rd; logic er; int we_before;
        int exp_gnt [4];
        reset = 1'b0; pl_we = 1'b0; pl_idx = '0; pl_dat = '0;
        set_port(0, 1'b0, 1'b0, '0, '0, '0);
        set_port(1, 1'b0, 1'b0, '0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack0", {31'd0, ack0}, 0);   chk("rst_ack1", {31'd0, ack1}, 0);
        chk("rst_err0", {31'd0, err0}, 0);   chk("rst_err1", {31'd0, err1}, 0);
        chk("rst_rdata0", rdata0, 0);        chk("rst_rdata1", rdata1, 0);
        chk("rst_ram_we", {31'd0, ram_we}, 0); chk("rst_ram_re", {31'd0, ram_re}, 0);
        chk("rst_ram_addr", {18'd0, ram_addr}, 0); chk("rst_ram_wdata", ram_wdata, 0);

        preload(14'h0010, 32'h0);
        preload(14'h0008, 32'hCAFEF00D);
        preload(14'h0020, 32'h11223344);
        preload(14'h0030, 32'h55667788);
        for (int i = 0; i < 4; i++) begin
            preload(AW'(32'h40 + i * 4), 32'hA0000000 + i);
            preload(AW'(32'h80 + i * 4), 32'hB0000000 + i);
        end
        @(posedge clk); #1; pl_we = 1'b0;
        @(posedge clk); #1; reset = 1'b1;

        // Full write then read back on port 0.
        we_before = tot_we;
        do_req(0, 1'b1, 14'h0010, 32'hDEADBEEF, 4'hF, lat, rd, er);
        chk("fullwr_latency", lat, 2);
        chk("fullwr_we_pulses", tot_we - we_before, 1);
        do_req(0, 1'b0, 14'h0010, 32'h0, 4'h0, lat, rd, er);
        chk("read_latency", lat, 2);
        chk("read_data", rd, 32'hDEADBEEF);

        // Byte-lane 1 store from port 1: read-modify-write.
        do_req(1, 1'b1, 14'h0020, 32'h0000AA00, 4'b0010, lat, rd, er);
        chk("partial_latency", lat, 3);
        chk("partial_merged", last_we_data, 32'h1122AA44);
        chk("partial_re_then_we", last_we_cyc - last_re_cyc, 1);
        chk("partial_ram", ram[12'h008], 32'h1122AA44);

        // Upper halfword store from port 0.
        do_req(0, 1'b1, 14'h0030, 32'hABCD0000, 4'b1100, lat, rd, er);
        chk("half_latency", lat, 3);
        chk("half_ram", ram[12'h00C], 32'hABCD7788);

        // Misaligned read and empty-byte-enable write both fail without touching RAM.
        do_req(0, 1'b0, 14'h0006, 32'h0, 4'h0, lat, rd, er);
        chk("misalign_latency", lat, 1);
        chk("misalign_err", {31'd0, er}, 1);
        chk("misalign_rdata", rd, 0);
        do_req(1, 1'b1, 14'h0008, 32'h12345678, 4'h0, lat, rd, er);
        chk("be0_latency", lat, 1);
        chk("be0_err", {31'd0, er}, 1);
        chk("be0_ram", ram[12'h002], 32'hCAFEF00D);

        // Reset asserted during MERGE of a port 1 partial write.
        @(posedge clk); #1;
        set_port(1, 1'b1, 1'b1, 14'h0020, 32'h000000EE, 4'b0001);
        repeat (3) @(negedge clk);
        chk("merge_we_before_reset", {31'd0, ram_we}, 1);
        #2 reset = 1'b0;
        #1;
        chk("abort_ram_we", {31'd0, ram_we}, 0);
        chk("abort_ram_addr", {18'd0, ram_addr}, 0);
        chk("abort_ram_wdata", ram_wdata, 0);
        chk("abort_ack1", {31'd0, ack1}, 0);
        @(posedge clk); #1;
        set_port(1, 1'b0, 1'b0, '0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        chk("abort_ram_unchanged", ram[12'h008], 32'h1122AA44);
        reset = 1'b1;

        // Both ports stream reads; grant order after reset.
        fork
            port_stream(0, 4);
            port_stream(1, 4);
        join
        repeat (3) @(posedge clk);
`ifdef MEM_ARB_FIXED_PRIORITY_EN
        exp_gnt = '{0, 0, 0, 0};
`else
        exp_gnt = '{0, 1, 0, 1};
`endif
        chk("grant_count", grant_log.size(), 8);
        for (int i = 0; i < 4; i++)
            chk($sformatf("grant_order_%0d", i), (grant_log.size() > i) ? grant_log[i] : -1, exp_gnt[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port data RAM between two requesters: port 0 (CPU data side) and port 1 (debug/DMA loader).
- Arbitrates round-robin and sequences every RAM access.
- Partial-word (byte/halfword) stores become read-modify-write sequences, since the RAM only writes whole words.
- Sits between the requesters and the RAM's writeEnable/readEnable/address/writeDataIn/readData pins.

Parameters:
- ADDR_W, 14, byte-address width presented to the RAM.
- DATA_W, 32, word width (fixed at 32; byte enables are DATA_W/8 = 4).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- req0  input  1  port 0 request; held high until ack0.
- we0  input  1  port 0 write (1) / read (0).
- addr0  input  ADDR_W  port 0 byte address.
- wdata0  input  32  port 0 store data, already lane-aligned.
- be0  input  4  port 0 byte enables (bit i = byte lane i).
- ack0  output  1  one-cycle completion pulse.
- rdata0  output  32  read data, valid while ack0=1.
- err0  output  1  error flag, valid while ack0=1.
- req1, we1, addr1, wdata1, be1, ack1, rdata1, err1: same as port 0, for port 1.
- ram_we  output  1  drives RAM writeEnable.
- ram_re  output  1  drives RAM readEnable.
- ram_addr  output  ADDR_W  drives RAM address.
- ram_wdata  output  32  drives RAM writeDataIn.
- ram_rdata  input  32  RAM readData (combinational read).

Behaviour:
- States: IDLE, ACCESS, MERGE, DONE.
- Reset (reset=0, asynchronous): state=IDLE; ack*/err*/rdata*=0; ram_we=ram_re=0; ram_addr=ram_wdata=0; rr pointer set so port 0 wins the first tie. Reset asserted mid-access aborts immediately: no RAM write is issued and no ack is given.
- IDLE: sample req0/req1 and grant one.
  - Only one request: grant it.
  - Both requests: grant the port not granted last (round-robin).
  - On grant, latch the granted port's we/addr/wdata/be and the port id, update the rr pointer, go to ACCESS.
  - No request: stay in IDLE.
- Error check, made at grant: addr[1:0] != 0, or a write with be == 0.
  - Go straight to DONE with err=1.
  - No RAM cycle is issued.
- ACCESS:
  - Read: ram_re=1, ram_addr=latched addr; capture ram_rdata; go to DONE.
  - Full write (be=4'hF): ram_we=1, ram_wdata=wdata; go to DONE.
  - Partial write: ram_re=1; for each lane, merged byte i = be[i] ? wdata byte i : ram_rdata byte i; go to MERGE.
- MERGE: ram_we=1, ram_addr=latched addr, ram_wdata=merged word; go to DONE.
- DONE:
  - Granted port's ack=1 for exactly one cycle.
  - rdata = captured word for reads, 0 for writes.
  - err as determined at grant.
  - Go to IDLE.
- ram_we and ram_re are never both high, and are 0 in IDLE and DONE.
- Latency, measured from the IDLE grant cycle N:
  - Read / full write: ack in cycle N+2.
  - Partial write: ack in cycle N+3.
  - Error: ack in cycle N+1.
- Requester contract:
  - Keep req and payload stable until ack.
  - In the cycle after ack, drop req or present a new request.
  - A re-asserted req competes under round-robin; no back-to-back starvation.
- The non-granted port's req stays pending; its ack remains 0.
- Payload changes after grant are ignored, because all fields are latched at grant.

Optional Feature:
- MEM_ARB_FIXED_PRIORITY_EN defined: round-robin disabled; port 0 always wins ties; the rr pointer is not implemented.
- Undefined (default): round-robin as in Behaviour.

Test Plan:
- Port 0 full write addr=0x0010, wdata=0xDEADBEEF, be=F, then read 0x0010 -> write ack at grant+2 with one ram_we pulse; read ack0 with rdata0=0xDEADBEEF.
- RAM word 0x0020 = 0x11223344; port 1 write wdata=0x0000AA00, be=4'b0010 -> ram_re then ram_we in consecutive cycles; ram_wdata=0x1122AA44; ack1 at grant+3.
- req0 and req1 held continuously, both reads -> grants alternate 0,1,0,1 after reset. With MEM_ARB_FIXED_PRIORITY_EN: port 0 every grant while req0 stays asserted.
- Port 0 read addr=0x0006 -> ack0=1, err0=1 at grant+1; ram_re and ram_we stay 0.
- Partial write granted; reset driven low during MERGE -> outputs clear asynchronously; RAM word unchanged; no ack. After release, the first grant goes to port 0.
